// File: rtl/sdram_req_scheduler_pkg.sv
// Shared definitions for the SDRAM request scheduler: requester indices,
// bus widths and FSM state encoding.
package sdram_req_scheduler_pkg;

    localparam int NREQ_DEFAULT      = 4;
    localparam int BURST_MAX_DEFAULT = 4;

    localparam int REQ_CPU = 0;
    localparam int REQ_FIR = 1;
    localparam int REQ_MM  = 2;
    localparam int REQ_QS  = 3;

    localparam int ADDR_W = 24;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_e;

endpackage

// File: rtl/sdram_req_scheduler_picker.sv
// Round-robin priority picker: first asserted valid bit at or after ptr,
// wrapping modulo NREQ.
module rr_priority_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             any_valid,
    output logic [IDX_W-1:0] idx
);

    int              cand;
    logic [NREQ-1:0] shifted;

    // Scan from farthest to nearest so the entry closest to ptr wins last.
    always_comb begin
        any_valid = |valid;
        idx       = '0;
        cand      = 0;
        shifted   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand    = (int'(ptr) + k) % NREQ;
            shifted = valid >> cand;
            if (shifted[0]) begin
                idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sdram_req_scheduler.sv
// Arbitrates NREQ requesters onto one SDRAM controller port with round-robin
// bursts of up to BURST_MAX accesses and at most one read in flight.
module sdram_req_scheduler
    import sdram_req_scheduler_pkg::*;
#(
    parameter int NREQ      = NREQ_DEFAULT,
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W*NREQ-1:0]   req_address,
    input  logic [NREQ-1:0]          req_rw,
    input  logic [WORD_W*NREQ-1:0]   req_wdata,
    input  logic [NREQ-1:0]          req_in_valid,
    input  logic [NREQ-1:0]          req_prefetch_step,
    output logic [WORD_W-1:0]        req_rdata,
    output logic [NREQ-1:0]          req_busy,
    output logic [NREQ-1:0]          req_out_valid,
    output logic [ADDR_W-1:0]        controller_address,
    output logic                     controller_rw,
    output logic [WORD_W-1:0]        data_to_controller,
    output logic                     controller_in_valid,
    output logic                     controller_prefetch_step,
    input  logic [WORD_W-1:0]        data_from_controller,
    input  logic                     controller_busy,
    input  logic                     controller_out_valid
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               g_valid;
    logic               burst_last;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) >= NREQ - 1) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    rr_priority_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid     (req_in_valid),
        .ptr       (rr_ptr_q),
        .any_valid (pick_any),
        .idx       (pick_idx)
    );

    assign g_valid    = req_in_valid[grant_q];
    assign burst_last = (burst_cnt_q == CNT_W'(BURST_MAX - 1));

    // Granted requester is mirrored straight onto the controller port.
    always_comb begin
        controller_address       = req_address[int'(grant_q)*ADDR_W +: ADDR_W];
        controller_rw            = req_rw[grant_q];
        data_to_controller       = req_wdata[int'(grant_q)*WORD_W +: WORD_W];
        controller_prefetch_step = req_prefetch_step[grant_q];
        controller_in_valid      = (state_q == ST_ISSUE) && g_valid;

        req_busy = '1;
        if (state_q == ST_ISSUE && !controller_busy) begin
            req_busy = ~(NREQ'(1) << grant_q);
        end

        req_out_valid = '0;
        req_rdata     = '0;
        if (state_q == ST_WAIT_RD && controller_out_valid) begin
            req_out_valid = NREQ'(1) << rd_owner_q;
            req_rdata     = data_from_controller;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        rd_owner_d  = rd_owner_q;
        burst_cnt_d = burst_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!g_valid) begin
                    state_d     = ST_IDLE;
                    rr_ptr_d    = next_idx(grant_q);
                    burst_cnt_d = '0;
                end else if (!controller_busy) begin
                    if (!req_rw[grant_q]) begin
                        state_d    = ST_WAIT_RD;
                        rd_owner_d = grant_q;
                    end else if (!burst_last) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end else begin
                        state_d     = ST_IDLE;
                        rr_ptr_d    = next_idx(grant_q);
                        burst_cnt_d = '0;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (controller_out_valid) begin
                    if (!burst_last) begin
                        state_d     = ST_ISSUE;
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end else begin
                        state_d     = ST_IDLE;
                        rr_ptr_d    = next_idx(grant_q);
                        burst_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            rd_owner_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            rd_owner_q  <= rd_owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_sdram_req_scheduler.sv
// Self-checking bench: per-cycle comparison against a transaction-level model
// plus directed scenarios with literal expectations.
module tb_sdram_req_scheduler;
    import sdram_req_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int BM = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [24*N-1:0]   req_address = '0;
    logic [N-1:0]      req_rw = '0;
    logic [32*N-1:0]   req_wdata = '0;
    logic [N-1:0]      req_in_valid = '0;
    logic [N-1:0]      req_prefetch_step = 4'b1010;
    logic [31:0]       req_rdata;
    logic [N-1:0]      req_busy;
    logic [N-1:0]      req_out_valid;
    logic [23:0]       controller_address;
    logic              controller_rw;
    logic [31:0]       data_to_controller;
    logic              controller_in_valid;
    logic              controller_prefetch_step;
    logic [31:0]       data_from_controller = '0;
    logic              controller_busy = 1'b0;
    logic              controller_out_valid = 1'b0;

    always #5 clk = ~clk;

    sdram_req_scheduler #(.NREQ(N), .BURST_MAX(BM)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .req_address              (req_address),
        .req_rw                   (req_rw),
        .req_wdata                (req_wdata),
        .req_in_valid             (req_in_valid),
        .req_prefetch_step        (req_prefetch_step),
        .req_rdata                (req_rdata),
        .req_busy                 (req_busy),
        .req_out_valid            (req_out_valid),
        .controller_address       (controller_address),
        .controller_rw            (controller_rw),
        .data_to_controller       (data_to_controller),
        .controller_in_valid      (controller_in_valid),
        .controller_prefetch_step (controller_prefetch_step),
        .data_from_controller     (data_from_controller),
        .controller_busy          (controller_busy),
        .controller_out_valid     (controller_out_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: who owns the port (-1 = nobody), whether a read is in flight,
    // accesses served in this burst, and where the next search starts.
    int m_owner = -1;
    bit m_pend  = 0;
    int m_cnt   = 0;
    int m_ptr   = 0;
    bit cmp_on  = 0;

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    task m_close();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
    endtask

    task m_served();
        if (m_cnt < BM - 1) m_cnt++;
        else m_close();
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_pend = 0; m_cnt = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            for (int j = N - 1; j >= 0; j--)
                if (bit_of(req_in_valid, (m_ptr + j) % N)) m_owner = (m_ptr + j) % N;
        end else if (!m_pend) begin
            if (!bit_of(req_in_valid, m_owner)) m_close();
            else if (!controller_busy) begin
                if (bit_of(req_rw, m_owner)) m_served();
                else m_pend = 1;
            end
        end else if (controller_out_valid) begin
            m_pend = 0;
            m_served();
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_busy, e_ov;
        logic         e_civ;
        logic [31:0]  e_rd;
        if (cmp_on) begin
            e_busy = '1; e_ov = '0; e_civ = 0; e_rd = '0;
            if (m_owner >= 0 && !m_pend) begin
                e_civ = bit_of(req_in_valid, m_owner);
                if (!controller_busy) e_busy[m_owner] = 1'b0;
            end
            if (m_owner >= 0 && m_pend && controller_out_valid) begin
                e_ov[m_owner] = 1'b1;
                e_rd = data_from_controller;
            end
            chk("req_busy", 32'(req_busy), 32'(e_busy));
            chk("controller_in_valid", 32'(controller_in_valid), 32'(e_civ));
            chk("req_out_valid", 32'(req_out_valid), 32'(e_ov));
            chk("req_rdata", req_rdata, e_rd);
            if (e_civ) begin
                chk("controller_address", 32'(controller_address), 32'(req_address[m_owner*24 +: 24]));
                chk("controller_rw", 32'(controller_rw), 32'(bit_of(req_rw, m_owner)));
                chk("data_to_controller", data_to_controller, req_wdata[m_owner*32 +: 32]);
                chk("controller_prefetch", 32'(controller_prefetch_step), 32'(bit_of(req_prefetch_step, m_owner)));
            end
        end
    end

    // Controller read emulation and observation logs.
    int          acc_log[$];
    int          ov_cnt[N];
    logic [31:0] last_rdata = '0;
    int          rd_cnt = 0;
    int          rd_lat = 5;
    logic [31:0] rd_data = 32'h12345678;

    task tick();
        bit rd_acc;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (req_in_valid[i] && !req_busy[i]) acc_log.push_back(i);
            if (req_out_valid[i]) ov_cnt[i]++;
        end
        if (|req_out_valid) last_rdata = req_rdata;
        rd_acc = controller_in_valid && !controller_busy && !controller_rw;
        @(posedge clk);
        #1;
        if (rd_cnt > 0) rd_cnt--;
        if (rd_acc) rd_cnt = rd_lat;
        controller_out_valid = (rd_cnt == 1);
        data_from_controller = (rd_cnt == 1) ? rd_data : 32'h0BAD_F00D;
    endtask

    task clear_logs();
        acc_log.delete();
        for (int i = 0; i < N; i++) ov_cnt[i] = 0;
        last_rdata = '0;
    endtask

    task do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp_on = 1'b1;
        clear_logs();
    endtask

    task set_req(input int i, input logic [23:0] a, input logic rw, input logic [31:0] d, input logic v);
        req_address[i*24 +: 24] = a;
        req_rw[i]               = rw;
        req_wdata[i*32 +: 32]   = d;
        req_in_valid[i]         = v;
    endtask

    task wait_accept(input string name);
        int n;
        n = 0;
        while (acc_log.size() == 0 && n < 30) begin
            tick();
            n++;
        end
        if (acc_log.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s no acceptance within 30 cycles", name);
        end
    endtask

    initial begin
        int s;
        tick();
        do_reset();
        #1;
        chk("reset_busy", 32'(req_busy), 32'hF);
        chk("reset_civ", 32'(controller_in_valid), 0);
        chk("reset_out_valid", 32'(req_out_valid), 0);
        chk("reset_rdata", req_rdata, 0);

        // Single CPU write
        set_req(REQ_CPU, 24'h000010, 1'b1, 32'hDEADBEEF, 1'b1);
        #1;
        chk("wr_cycle1_civ", 32'(controller_in_valid), 0);
        tick();
        #1;
        chk("wr_cycle2_civ", 32'(controller_in_valid), 1);
        chk("wr_cycle2_busy0", 32'(req_busy[0]), 0);
        chk("wr_cycle2_data", data_to_controller, 32'hDEADBEEF);
        chk("wr_cycle2_addr", 32'(controller_address), 32'h000010);
        tick();
        req_in_valid = '0;
        chk("wr_accepts", 32'(acc_log.size()), 1);
        repeat (3) tick();

        // FIR read with 5-cycle controller latency
        do_reset();
        rd_lat = 5; rd_data = 32'h12345678;
        set_req(REQ_FIR, 24'h000100, 1'b0, 32'h0, 1'b1);
        wait_accept("fir_read_accept");
        req_in_valid = '0;
        repeat (10) tick();
        chk("rd_fir_pulses", 32'(ov_cnt[1]), 1);
        chk("rd_other_pulses", 32'(ov_cnt[0] + ov_cnt[2] + ov_cnt[3]), 0);
        chk("rd_fir_data", last_rdata, 32'h12345678);

        // All four requesters write continuously
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 24'(24'h1000 * (i + 1)), 1'b1, 32'hA000_0000 + i, 1'b1);
        repeat (45) tick();
        req_in_valid = '0;
        chk("rr_accept_count_ge32", 32'(acc_log.size() >= 32), 1);
        for (int k = 0; k < 32 && k < acc_log.size(); k++)
            chk($sformatf("rr_order[%0d]", k), 32'(acc_log[k]), 32'((k / 4) % 4));
        repeat (3) tick();

        // Controller busy holds off acceptance
        do_reset();
        controller_busy = 1'b1;
        set_req(REQ_CPU, 24'h000020, 1'b1, 32'h55AA55AA, 1'b1);
        tick();
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("busy_hold_busy0", 32'(req_busy[0]), 1);
            chk("busy_hold_civ", 32'(controller_in_valid), 1);
            tick();
        end
        chk("busy_hold_accepts", 32'(acc_log.size()), 0);
        controller_busy = 1'b0;
        tick();
        req_in_valid = '0;
        chk("busy_release_accepts", 32'(acc_log.size()), 1);
        repeat (3) tick();

        // Reset while a read is outstanding
        do_reset();
        rd_lat = 5; rd_data = 32'hCAFE0001;
        set_req(REQ_QS, 24'h000300, 1'b0, 32'h0, 1'b1);
        wait_accept("qs_read_accept");
        req_in_valid = '0;
        tick();
        do_reset();
        repeat (8) tick();
        s = ov_cnt[0] + ov_cnt[1] + ov_cnt[2] + ov_cnt[3];
        chk("rst_rd_no_pulse", 32'(s), 0);
        chk("rst_rd_idle_busy", 32'(req_busy), 32'hF);
        chk("rst_rd_idle_civ", 32'(controller_in_valid), 0);
        clear_logs();
        set_req(REQ_MM, 24'h000200, 1'b1, 32'h22222222, 1'b1);
        set_req(REQ_CPU, 24'h000040, 1'b1, 32'h11111111, 1'b1);
        tick();
        tick();
        req_in_valid = '0;
        chk("rst_rd_ptr0_first", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 0);
        repeat (4) tick();

        // MM withdraws before acceptance; QS follows
        do_reset();
        controller_busy = 1'b1;
        set_req(REQ_MM, 24'h000222, 1'b1, 32'h33333333, 1'b1);
        set_req(REQ_QS, 24'h000333, 1'b1, 32'h44444444, 1'b1);
        tick();
        #1;
        chk("mm_grant_addr", 32'(controller_address), 32'h000222);
        req_in_valid[REQ_MM] = 1'b0;
        tick();
        #1;
        chk("mm_drop_idle_civ", 32'(controller_in_valid), 0);
        chk("mm_drop_idle_busy", 32'(req_busy), 32'hF);
        controller_busy = 1'b0;
        tick();
        #1;
        chk("qs_next_civ", 32'(controller_in_valid), 1);
        chk("qs_next_addr", 32'(controller_address), 32'h000333);
        chk("qs_next_busy", 32'(req_busy), 32'h7);
        tick();
        req_in_valid = '0;
        chk("qs_accepted", 32'(acc_log.size() == 1 && acc_log[0] == REQ_QS), 1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
